ad7606_emu: RTL and testbench

Synthesizable behavioural model of the AD7606 8-channel ADC that answers the ad7606 controller on the same pins: convst (cva/cvb), cs_n/rd_n parallel read, os, rst_ad7606, busy, data.
Drives a deterministic, self-checking sample pattern so that the controller, its downstream key/LED logic and the UART path can be exercised in simulation and on hardware without the real ADC.
Runs in the controller's clk_50 domain, so every input is sampled directly with no synchronizer.

---
 rtl/ad7606_pkg.sv | 14 +
 rtl/ad7606_if.sv | 16 +
 rtl/ad7606_conv_timer.sv | 57 +++++
 rtl/ad7606_emu.sv | 86 ++++++++
 tb/tb_ad7606_emu.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ad7606_pkg.sv
// ad7606_pkg: shared constants, FSM state type and the sample pattern rule
package ad7606_pkg;
   localparam int NUM_CH = 8;
   localparam int DATA_W = 16;
   localparam int CH_W   = 3;
   localparam int OS_MAX = 6;
   localparam int CNT_W  = DATA_W - CH_W;

   typedef enum logic {IDLE, CONV} conv_state_t;

   function automatic logic [DATA_W-1:0] sample_pattern(input logic [CNT_W-1:0] conv_cnt, input logic [CH_W-1:0] ch);
      return {conv_cnt, ch};
   endfunction
endpackage

// File: rtl/ad7606_if.sv
// ad7606_if: AD7606 parallel-bus pins between controller (master) and ADC (slave)
interface ad7606_if;
   import ad7606_pkg::*;
   logic              rst_ad7606;
   logic              cva;
   logic              cvb;
   logic              cs_n;
   logic              rd_n;
   logic [2:0]        os;
   logic              busy;
   logic [DATA_W-1:0] data;
   logic              frstdata;

   modport master (output rst_ad7606, cva, cvb, cs_n, rd_n, os, input busy, data, frstdata);
   modport slave  (input rst_ad7606, cva, cvb, cs_n, rd_n, os, output busy, data, frstdata);
endinterface

// File: rtl/ad7606_conv_timer.sv
// ad7606_conv_timer: busy-length computation from os and the conversion down-counter
module ad7606_conv_timer
   import ad7606_pkg::*;
#(
   parameter int BUSY_CYCLES = 200
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       start,
   input  logic       clear,
   input  logic [2:0] os,
   output logic       busy,
   output logic       done
);
   localparam int TMR_W = $clog2((BUSY_CYCLES << OS_MAX) + 1);

   conv_state_t      state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [2:0]       os_eff;
   logic [TMR_W-1:0] t_load;

   assign os_eff = (os > 3'(OS_MAX)) ? 3'd0 : os;
   assign t_load = (TMR_W'(BUSY_CYCLES) << os_eff) - TMR_W'(1);
   assign busy   = (state == CONV);

   // state and timer registers
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // next state: load on start, count down, pulse done on the last busy cycle
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      done      = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         timer_nxt = '0;
      end else if (state == IDLE) begin
         if (start) begin
            state_nxt = CONV;
            timer_nxt = t_load;
         end
      end else if (timer == '0) begin
         state_nxt = IDLE;
         done      = 1'b1;
      end else begin
         timer_nxt = timer - TMR_W'(1);
      end
   end
endmodule

// File: rtl/ad7606_emu.sv
// ad7606_emu: behavioural AD7606 answering the controller with a deterministic sample pattern
module ad7606_emu
   import ad7606_pkg::*;
#(
   parameter int BUSY_CYCLES = 200
) (
   input logic     clk_50,
   input logic     rst_n,
   ad7606_if.slave bus
);
   logic              cv;
   logic              cv_d;
   logic              rd_d;
   logic              conv_start;
   logic              rd_fall;
   logic              done;
   logic [CNT_W-1:0]  conv_cnt;
   logic [CH_W-1:0]   ch_ptr;
   logic [DATA_W-1:0] result [NUM_CH];

   assign cv         = bus.cva & bus.cvb;
   assign conv_start = cv & ~cv_d & ~bus.busy & ~bus.rst_ad7606;
   assign rd_fall    = ~bus.rd_n & rd_d & ~bus.cs_n;

   ad7606_conv_timer #(.BUSY_CYCLES(BUSY_CYCLES)) u_timer (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .start  (conv_start),
      .clear  (bus.rst_ad7606),
      .os     (bus.os),
      .busy   (bus.busy),
      .done   (done)
   );

   // one-cycle history of convst (both halves) and rd_n for edge detection
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         cv_d <= 1'b0;
         rd_d <= 1'b0;
      end else if (bus.rst_ad7606) begin
         cv_d <= 1'b0;
         rd_d <= 1'b0;
      end else begin
         cv_d <= cv;
         rd_d <= bus.rd_n;
      end
   end

   // latch a fresh result bank and advance the conversion counter when a conversion ends
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         conv_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
      end else if (bus.rst_ad7606) begin
         conv_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
      end else if (done) begin
         conv_cnt <= conv_cnt + 1'b1;
         for (int i = 0; i < NUM_CH; i++) result[i] <= sample_pattern(conv_cnt, CH_W'(i));
      end
   end

   // read pointer and output registers; a read coinciding with conversion end returns the new channel 0
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         ch_ptr       <= '0;
         bus.data     <= '0;
         bus.frstdata <= 1'b0;
      end else if (bus.rst_ad7606) begin
         ch_ptr       <= '0;
         bus.data     <= '0;
         bus.frstdata <= 1'b0;
      end else begin
         if (done)
            ch_ptr <= rd_fall ? CH_W'(1) : CH_W'(0);
         else if (rd_fall)
            ch_ptr <= ch_ptr + 1'b1;
         if (rd_fall) begin
            bus.data     <= done ? sample_pattern(conv_cnt, CH_W'(0)) : result[ch_ptr];
            bus.frstdata <= done | (ch_ptr == CH_W'(0));
         end else if (bus.cs_n) begin
            bus.frstdata <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ad7606_emu.sv
// tb_ad7606_emu: directed stimulus with scoreboard queues for read data and busy lengths
module tb_ad7606_emu;
   logic        clk_50 = 1'b0;
   logic        rst_n  = 1'b0;
   int          tests  = 0;
   int          fails  = 0;
   logic [16:0] exp_rd [$];
   int          exp_busy [$];
   int          busy_len = 0;
   logic        mon_rd_d = 1'b1;

   ad7606_if bus();

   ad7606_emu #(.BUSY_CYCLES(200)) dut (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #10 clk_50 = ~clk_50;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   task automatic convst();
      bus.cva = 1'b1;
      bus.cvb = 1'b1;
      tick(1);
      bus.cva = 1'b0;
      bus.cvb = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 20000) begin
         tick(1);
         n++;
      end
      if (bus.busy) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: busy still high after %0d cycles, required low", n);
      end
      tick(2);
   endtask

   task automatic rd(input logic [15:0] d, input logic f);
      exp_rd.push_back({f, d});
      bus.cs_n = 1'b0;
      bus.rd_n = 1'b0;
      tick(1);
      bus.rd_n = 1'b1;
      bus.cs_n = 1'b1;
      tick(1);
   endtask

   // read monitor: a read strobe seen at a clock edge is checked half a cycle later
   always @(posedge clk_50) begin
      logic        hit;
      logic [16:0] e;
      hit = rst_n && !bus.rd_n && mon_rd_d && !bus.cs_n;
      mon_rd_d = bus.rd_n;
      if (hit) begin
         @(negedge clk_50);
         if (exp_rd.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got data 0x%0h with no expected read", bus.data);
         end else begin
            e = exp_rd.pop_front();
            chk("rd_data", 32'(bus.data), 32'(e[15:0]));
            chk("rd_frstdata", 32'(bus.frstdata), 32'(e[16]));
         end
      end
   end

   // busy monitor: measures each busy pulse and compares its length on the falling edge
   always @(negedge clk_50) begin
      if (bus.busy) begin
         busy_len++;
      end else if (busy_len > 0) begin
         if (exp_busy.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL busy_unexpected: got busy pulse of %0d cycles, required none", busy_len);
         end else begin
            chk("busy_len", busy_len, exp_busy.pop_front());
         end
         busy_len = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      logic seen;
      bus.cva = 1'b0;
      bus.cvb = 1'b0;
      bus.cs_n = 1'b1;
      bus.rd_n = 1'b1;
      bus.os = 3'd0;
      bus.rst_ad7606 = 1'b0;
      tick(3);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_data", 32'(bus.data), 32'h0);
      chk("reset_frstdata", 32'(bus.frstdata), 32'h0);
      rst_n = 1'b1;
      tick(2);

      // os=0 conversion, eight reads
      bus.os = 3'd0;
      exp_busy.push_back(200);
      convst();
      wait_idle();
      for (int i = 0; i < 8; i++) rd(16'h0000 + 16'(i), i == 0);

      // os=2 conversion with os changed mid-conversion, then a wrapping 9th read
      bus.os = 3'd2;
      exp_busy.push_back(800);
      convst();
      bus.os = 3'd5;
      wait_idle();
      for (int i = 0; i < 8; i++) rd(16'h0008 + 16'(i), i == 0);
      rd(16'h0008, 1'b1);

      // os=7 behaves as os=0
      bus.os = 3'd7;
      exp_busy.push_back(200);
      convst();
      wait_idle();
      rd(16'h0010, 1'b1);

      // extra convst edge during busy is ignored
      bus.os = 3'd0;
      exp_busy.push_back(200);
      convst();
      tick(49);
      bus.cva = 1'b1;
      bus.cvb = 1'b1;
      tick(1);
      bus.cva = 1'b0;
      bus.cvb = 1'b0;
      wait_idle();

      // single-half convst edges never start a conversion
      seen = 1'b0;
      bus.cva = 1'b1;
      repeat (5) begin
         tick(1);
         seen |= bus.busy;
      end
      bus.cva = 1'b0;
      tick(2);
      chk("cva_only_busy", 32'(seen), 32'h0);
      seen = 1'b0;
      bus.cvb = 1'b1;
      repeat (5) begin
         tick(1);
         seen |= bus.busy;
      end
      bus.cvb = 1'b0;
      tick(2);
      chk("cvb_only_busy", 32'(seen), 32'h0);
      rd(16'h0018, 1'b1);

      // rst_ad7606 aborts a conversion and clears the counter and results
      exp_busy.push_back(100);
      convst();
      tick(99);
      bus.rst_ad7606 = 1'b1;
      tick(1);
      bus.rst_ad7606 = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'h0);
      tick(2);
      rd(16'h0000, 1'b1);
      exp_busy.push_back(200);
      convst();
      wait_idle();
      for (int i = 0; i < 8; i++) rd(16'h0000 + 16'(i), i == 0);

      // read strobe on the same edge that ends the conversion
      exp_busy.push_back(200);
      convst();
      tick(199);
      exp_rd.push_back({1'b1, 16'h0008});
      bus.cs_n = 1'b0;
      bus.rd_n = 1'b0;
      tick(1);
      bus.rd_n = 1'b1;
      bus.cs_n = 1'b1;
      tick(1);
      rd(16'h0009, 1'b0);
      wait_idle();

      tick(5);
      chk("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
      chk("busy_queue_empty", 32'(exp_busy.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
